uart_rx_parity: RTL and testbench
=================================

Name: uart_rx_parity

Overview:
UART receiver that consumes the serial line driven by the team's even-parity UART transmitter. Frame format is 1 start bit (0), 8 data bits LSB-first, 1 even-parity bit, and 1 stop bit (1). The line is oversampled at 16x baud, and each bit is sampled at its centre. Each frame produces a one-cycle rx_dv pulse with the received byte, a parity-error flag and a framing-error flag.

Parameters:
OVERSAMPLE, 16, ticks per bit period; must be even and >= 4
DATA_BITS, 8, data bits per frame
SYNC_STAGES, 2, flip-flops in the serial_in synchroniser

Ports:
clk  in  1  system clock
rst  in  1  reset
count  in  8  oversample divisor; one tick every (count+1) clk cycles
serial_in  in  1  asynchronous UART line, idle high
rx_dv  out  1  one-clk pulse: rx_byte, parity_err and frame_err are valid
rx_byte  out  8  last received byte, held until the next rx_dv
parity_err  out  1  received parity bit does not equal the XOR of the data bits; held with rx_byte
frame_err  out  1  stop bit sampled as 0; held with rx_byte
rx_active  out  1  high from start-bit detection until the frame completes or is aborted

Behaviour:
- Clocking and reset: clock clk; reset rst, asynchronous, active-high.
- Reset values: rx_dv=0, rx_byte=0, parity_err=0, frame_err=0, rx_active=0, synchroniser flip-flops=1, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately, with no rx_dv and no flag update.
- Tick generator:
  - Free-running counter 0..count; tick is a one-clk pulse when counter==count, then the counter wraps to 0.
  - count=0 gives a tick every clk.
  - A change of count takes effect at the next wrap.
- Synchroniser:
  - serial_in passes through SYNC_STAGES flip-flops; all decisions use the synchronised value rx_s.
  - Fixed input latency is SYNC_STAGES clk cycles.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - A per-state tick counter os_cnt (4 bits) is cleared on every state entry.
  - IDLE: rx_active=0. When rx_s==0, clear os_cnt and go to START.
  - START: rx_active=1. On the tick where os_cnt reaches OVERSAMPLE/2-1, sample rx_s.
    - rx_s==1: false start (glitch); go to IDLE with no output.
    - rx_s==0: clear os_cnt, clear bit_idx, go to DATA.
  - DATA: sample rx_s when os_cnt reaches OVERSAMPLE-1 (mid-bit) and shift it into bit position bit_idx (LSB first).
    - After bit_idx==DATA_BITS-1 is sampled, go to PARITY.
    - Otherwise increment bit_idx.
  - PARITY: mid-bit sample gives par_bit; go to STOP.
  - STOP: mid-bit sample.
    - Next clk: rx_dv=1 for exactly one cycle, rx_byte=shift register, parity_err=(^shift)^par_bit, frame_err=~rx_s, rx_active=0.
    - If the stop sample was 1, go to IDLE; otherwise go to WAIT_HIGH.
  - WAIT_HIGH (break or framing fault): stay until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Latency: rx_dv rises 1 clk after the stop-bit centre tick.
- A frame is always delivered, even with parity_err or frame_err set.
- Back-to-back frames:
  - A start edge arriving half a bit after the stop centre is detected.
  - rx_dv is never asserted in two consecutive cycles.
- Counter widths: os_cnt wraps naturally at 16; bit_idx is 3 bits. No other arithmetic.
- rx_dv does not depend on any upstream or downstream handshake. The consumer must take the byte within one frame time.

Decomposition:
- Shared package uart_pkg:
  - rx state encoding localparams (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, WAIT_HIGH=3'd5).
  - OVERSAMPLE default.
  - Frame-format constants (START_BIT=0, STOP_BIT=1, even parity).
- One sub-module, uart_os_tick_gen (clk, rst, count -> tick), instantiated once.
- The synchroniser stays inline.

Test Plan:
- count=0 (16 clk per bit); send 0xA5 as bits 0,1,0,1,0,0,1,0,1, parity 0, stop 1 -> one rx_dv pulse, rx_byte=0xA5, parity_err=0, frame_err=0.
- count=3 (64 clk per bit); send 0x07 with parity 1 -> rx_byte=0x07, parity_err=0. Send 0x07 with parity 0 -> rx_byte=0x07, parity_err=1, rx_dv still pulses.
- Line low for 4 ticks then high (glitch) -> rx_active pulses high then low, no rx_dv. The next valid 0x3C frame is received correctly.
- Send 0x55 with stop bit 0, line held low for 40 ticks -> rx_dv with frame_err=1. No new frame until the line returns high; a following 0x81 frame is received cleanly.
- Loopback from the team's transmitter with the same count: 4 back-to-back bytes 0x00, 0xFF, 0x5A, 0xC3 -> 4 rx_dv pulses, bytes in order, all flags 0.
- Assert rst during data bit 3 of a frame -> all outputs at reset values, no rx_dv. A frame after rst deasserts is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared frame-format constants and receiver state encoding for the UART blocks.
package uart_pkg;
    localparam int OVERSAMPLE_DEF = 16;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic PARITY_ODD = 1'b0;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        START = 3'd1,
        DATA = 3'd2,
        PARITY = 3'd3,
        STOP = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;
endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: oversample tick, one pulse every (count+1) clk cycles.
module uart_os_tick_gen (
    input logic clk,
    input logic rst,
    input logic [7:0] count,
    output logic tick
);
    logic [7:0] cnt;
    logic [7:0] lim;
    assign tick = cnt == lim;
    // The divisor is latched only at wrap so a mid-period change never stretches a period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            lim <= '0;
        end else if (tick) begin
            cnt <= '0;
            lim <= count;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8E1 UART receiver, centre-sampled at OVERSAMPLE x baud, with parity and framing flags.
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    input logic [7:0] count,
    input logic serial_in,
    output logic rx_dv,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic parity_err,
    output logic frame_err,
    output logic rx_active
);
    logic tick;
    logic [SYNC_STAGES-1:0] sync;
    logic rx_s;
    rx_state_t state;
    logic [3:0] os_cnt;
    logic [2:0] bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic par_bit;
    logic half;
    logic mid;

    uart_os_tick_gen u_tick (
        .clk(clk),
        .rst(rst),
        .count(count),
        .tick(tick)
    );

    assign rx_s = sync[SYNC_STAGES-1];
    assign half = tick && os_cnt == 4'(OVERSAMPLE / 2 - 1);
    assign mid = tick && os_cnt == 4'(OVERSAMPLE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], serial_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            os_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            par_bit <= 1'b0;
            rx_dv <= 1'b0;
            rx_byte <= '0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            rx_dv <= 1'b0;
            if (tick) os_cnt <= os_cnt + 4'd1;
            case (state)
                IDLE: begin
                    if (rx_s == START_BIT) begin
                        os_cnt <= '0;
                        rx_active <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (half) begin
                        os_cnt <= '0;
                        bit_idx <= '0;
                        rx_active <= rx_s == START_BIT;
                        state <= rx_s == START_BIT ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (mid) begin
                        os_cnt <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (mid) begin
                        os_cnt <= '0;
                        par_bit <= rx_s;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        os_cnt <= '0;
                        rx_dv <= 1'b1;
                        rx_byte <= shift;
                        parity_err <= (^shift) ^ par_bit ^ PARITY_ODD;
                        frame_err <= rx_s != STOP_BIT;
                        rx_active <= 1'b0;
                        state <= rx_s == STOP_BIT ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s == STOP_BIT) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_parity.sv
// tb_uart_rx_parity: directed frame vectors plus glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx_parity;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] count = 8'd0;
    logic serial_in = 1'b1;
    logic rx_dv;
    logic [7:0] rx_byte;
    logic parity_err;
    logic frame_err;
    logic rx_active;

    int tests = 0;
    int fails = 0;
    int b2b = 0;
    logic dv_d = 1'b0;

    typedef struct packed {
        logic [7:0] b;
        logic pe;
        logic fe;
    } frame_t;
    frame_t q[$];

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] d;
        logic p;
        logic s;
        logic [7:0] eb;
        logic epe;
        logic efe;
    } vec_t;
    vec_t vecs[6];

    uart_rx_parity dut (
        .clk(clk),
        .rst(rst),
        .count(count),
        .serial_in(serial_in),
        .rx_dv(rx_dv),
        .rx_byte(rx_byte),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .rx_active(rx_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_dv) q.push_back({rx_byte, parity_err, frame_err});
        if (rx_dv && dv_d) b2b <= b2b + 1;
        dv_d <= rx_dv;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line(input logic v, input int clks);
        serial_in = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int bc);
        line(1'b0, bc);
        for (int i = 0; i < 8; i++) line(d[i], bc);
        line(p, bc);
        line(s, bc);
    endtask

    task automatic expect_frame(input string name, input logic [7:0] b, input logic pe, input logic fe);
        frame_t f;
        chk({name, "_n"}, q.size(), 1);
        if (q.size() > 0) begin
            f = q.pop_front();
            chk({name, "_byte"}, f.b, b);
            chk({name, "_pe"}, f.pe, pe);
            chk({name, "_fe"}, f.fe, fe);
        end
        q.delete();
    endtask

    initial begin
        int bc;
        logic seen;
        logic [7:0] lb[4];
        vecs[0] = '{8'd0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'd3, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'd3, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'd0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'd1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'd0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        lb = '{8'h00, 8'hFF, 8'h5A, 8'hC3};

        repeat (3) @(negedge clk);
        chk("rst_dv", rx_dv, 0);
        chk("rst_byte", rx_byte, 0);
        chk("rst_pe", parity_err, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_active", rx_active, 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            count = vecs[v].cnt;
            bc = 16 * (vecs[v].cnt + 1);
            line(1'b1, 2 * bc);
            q.delete();
            send_frame(vecs[v].d, vecs[v].p, vecs[v].s, bc);
            line(1'b1, 2 * bc);
            expect_frame($sformatf("vec%0d", v), vecs[v].eb, vecs[v].epe, vecs[v].efe);
            chk($sformatf("vec%0d_active", v), rx_active, 0);
        end

        count = 8'd3;
        bc = 64;
        line(1'b1, 2 * bc);
        seen = 1'b0;
        serial_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen |= rx_active;
        end
        line(1'b1, bc);
        chk("glitch_seen_active", seen, 1);
        chk("glitch_active_low", rx_active, 0);
        chk("glitch_no_dv", q.size(), 0);
        send_frame(8'h3C, 1'b0, 1'b1, bc);
        line(1'b1, 2 * bc);
        expect_frame("after_glitch", 8'h3C, 1'b0, 1'b0);

        count = 8'd0;
        bc = 16;
        line(1'b1, 2 * bc);
        send_frame(8'h55, 1'b0, 1'b0, bc);
        line(1'b0, 40);
        chk("break_active_low", rx_active, 0);
        expect_frame("break", 8'h55, 1'b0, 1'b1);
        line(1'b0, 8 * bc);
        chk("break_hold_no_dv", q.size(), 0);
        line(1'b1, 2 * bc);
        chk("break_release_no_dv", q.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1, bc);
        line(1'b1, 2 * bc);
        expect_frame("after_break", 8'h81, 1'b0, 1'b0);

        count = 8'd2;
        bc = 48;
        line(1'b1, 2 * bc);
        for (int i = 0; i < 4; i++) send_frame(lb[i], ^lb[i], 1'b1, bc);
        line(1'b1, 2 * bc);
        chk("b2b_n", q.size(), 4);
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            frame_t f;
            f = q.pop_front();
            chk($sformatf("b2b%0d_byte", i), f.b, lb[i]);
            chk($sformatf("b2b%0d_flags", i), {f.pe, f.fe}, 2'b00);
        end
        q.delete();

        count = 8'd0;
        bc = 16;
        line(1'b1, 2 * bc);
        line(1'b0, bc);
        for (int i = 0; i < 3; i++) line(1'b1, bc);
        line(1'b1, 8);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dv", rx_dv, 0);
        chk("mid_rst_byte", rx_byte, 0);
        chk("mid_rst_flags", {parity_err, frame_err}, 2'b00);
        chk("mid_rst_active", rx_active, 0);
        line(1'b1, 4);
        rst = 1'b0;
        line(1'b1, 2 * bc);
        chk("mid_rst_no_dv", q.size(), 0);
        send_frame(8'h96, 1'b0, 1'b1, bc);
        line(1'b1, 2 * bc);
        expect_frame("after_rst", 8'h96, 1'b0, 1'b0);

        chk("dv_never_consecutive", b2b, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
